// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch instruction queue.
//  fqEntry_t      : one queued instruction {inst, pc, exc}
//  FQ_PTR_W       : queue pointer width (log2 of depth)
//  compactOffsets : per-lane write offset (prefix popcount of lower valid lanes)
//  laneCount      : number of valid lanes in a fetch group
package fetch_queue_pkg;
  localparam int FQ_FETCH_W = 4;
  localparam int FQ_DEQ_W   = 4;
  localparam int FQ_DEPTH   = 16;
  localparam int FQ_INST_W  = 32;
  localparam int FQ_PC_W    = 64;
  localparam int FQ_PTR_W   = $clog2(FQ_DEPTH);
  localparam int FQ_LANE_W  = $clog2(FQ_FETCH_W) + 1;

  typedef struct packed {
    logic [FQ_INST_W-1:0] inst;
    logic [FQ_PC_W-1:0]   pc;
    logic                 exc;
  } fqEntry_t;

  localparam int FQ_ENTRY_W = $bits(fqEntry_t);

  typedef logic [FQ_FETCH_W-1:0][FQ_LANE_W-1:0] fqLaneOff_t;

  // Lane i lands at tail + (number of valid lanes below i), squeezing out gaps.
  function automatic fqLaneOff_t compactOffsets(input logic [FQ_FETCH_W-1:0] valid);
    fqLaneOff_t           off;
    logic [FQ_LANE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FQ_FETCH_W; i++) begin
      off[i] = acc;
      acc    = acc + FQ_LANE_W'(valid[i]);
    end
    return off;
  endfunction

  function automatic logic [FQ_LANE_W-1:0] laneCount(input logic [FQ_FETCH_W-1:0] valid);
    logic [FQ_LANE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FQ_FETCH_W; i++) acc = acc + FQ_LANE_W'(valid[i]);
    return acc;
  endfunction
endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH entries, WR_PORTS synchronous
// write ports, RD_PORTS asynchronous read ports. Write addresses within one
// cycle are always distinct (consecutive compacted slots).
//  clk    : clock
//  we     : per-port write enable
//  waddr  : per-port write address
//  wdata  : per-port packed fqEntry_t
//  raddr  : per-port read address
//  rdata  : per-port packed fqEntry_t (combinational)
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = FQ_DEPTH,
  parameter int WR_PORTS = FQ_FETCH_W,
  parameter int RD_PORTS = FQ_DEQ_W,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic [WR_PORTS-1:0]                  we,
  input  logic [WR_PORTS-1:0][AW-1:0]          waddr,
  input  logic [WR_PORTS-1:0][FQ_ENTRY_W-1:0]  wdata,
  input  logic [RD_PORTS-1:0][AW-1:0]          raddr,
  output logic [RD_PORTS-1:0][FQ_ENTRY_W-1:0]  rdata
);
  logic [FQ_ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++)
      if (we[i]) mem[waddr[i]] <= wdata[i];
  end

  always_comb begin
    for (int k = 0; k < RD_PORTS; k++) rdata[k] = mem[raddr[k]];
  end
endmodule

// File: rtl/fetch_inst_queue.sv
// Decoupling queue between I-cache fetch and decode. Accepts up to
// FETCH_WIDTH lanes per cycle (compacted in lane order), presents the
// DEQ_WIDTH oldest entries to decode, and stalls fetch only when fewer than
// FETCH_WIDTH slots are free. An exception group collapses to one tagged
// entry. Optional macro FETCH_QUEUE_BYPASS_EN: when empty, incoming lanes
// drive the dequeue outputs in the same cycle.
// Ports:
//  clk, reset     : clock, synchronous active-high reset
//  flush_i        : drop all contents (wins over enqueue/dequeue)
//  fetchPC_i      : PC of lane 0 (lane i = +4*i)
//  inst_i         : FETCH_WIDTH instructions, lane 0 in the low bits
//  instValid_i    : per-lane valid
//  instExc_i      : fetch exception on this group
//  fqReady_o      : at least FETCH_WIDTH free slots (registered count only)
//  deqInst_o/PC_o/Exc_o/Valid_o : oldest entries, slot 0 oldest
//  deqCnt_i       : slots consumed by decode this cycle
//  count_o        : occupancy
module fetch_inst_queue
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = FQ_FETCH_W,
  parameter int DEQ_WIDTH   = FQ_DEQ_W,
  parameter int DEPTH       = FQ_DEPTH,
  parameter int INST_W      = FQ_INST_W,
  parameter int PC_W        = FQ_PC_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [PC_W-1:0]               fetchPC_i,
  input  logic [FETCH_WIDTH*INST_W-1:0] inst_i,
  input  logic [FETCH_WIDTH-1:0]        instValid_i,
  input  logic                          instExc_i,
  output logic                          fqReady_o,
  output logic [DEQ_WIDTH*INST_W-1:0]   deqInst_o,
  output logic [DEQ_WIDTH*PC_W-1:0]     deqPC_o,
  output logic [DEQ_WIDTH-1:0]          deqExc_o,
  output logic [DEQ_WIDTH-1:0]          deqValid_o,
  input  logic [$clog2(DEQ_WIDTH):0]    deqCnt_i,
  output logic [$clog2(DEPTH):0]        count_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DC_W  = $clog2(DEQ_WIDTH) + 1;

  logic [FQ_PTR_W-1:0] head, tail;
  logic [CNT_W-1:0]    count;

  logic [FETCH_WIDTH-1:0] effValid;
  fqLaneOff_t             laneOff;
  logic [FQ_LANE_W-1:0]   enqTotal, enqCnt;
  logic                   enqFire, bypass;
  logic [DC_W-1:0]        bypShift;

  fqEntry_t [FETCH_WIDTH-1:0]                laneEntry;
  logic [FETCH_WIDTH-1:0]                    wrEn;
  logic [FETCH_WIDTH-1:0][FQ_PTR_W-1:0]      wrAddr;
  logic [FETCH_WIDTH-1:0][FQ_ENTRY_W-1:0]    wrData;
  logic [DEQ_WIDTH-1:0][FQ_PTR_W-1:0]        rdAddr;
  logic [DEQ_WIDTH-1:0][FQ_ENTRY_W-1:0]      rdData;
  fqEntry_t [DEQ_WIDTH-1:0]                  slotEntry;

  // Exception group: keep only the lowest valid lane (lane 0 if none valid).
  always_comb begin
    effValid = instValid_i;
    if (instExc_i)
      effValid = (instValid_i == '0) ? FETCH_WIDTH'(1) : (instValid_i & (~instValid_i + FETCH_WIDTH'(1)));
  end

  assign laneOff   = compactOffsets(effValid);
  assign enqTotal  = laneCount(effValid);
  assign fqReady_o = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign enqFire   = fqReady_o & ~flush_i & ~reset;
  assign enqCnt    = enqFire ? enqTotal : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = enqFire && (count == '0);
`else
  assign bypass = 1'b0;
`endif
  // Entries consumed straight off the bypass are never written; the rest
  // shift down so they start at tail, and head stays put.
  assign bypShift = bypass ? deqCnt_i : '0;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : gLane
    assign laneEntry[i] = '{inst: inst_i[i*INST_W +: INST_W],
                            pc:   fetchPC_i + PC_W'(4*i),
                            exc:  instExc_i};
    assign wrEn[i]   = enqFire & effValid[i] & (laneOff[i] >= FQ_LANE_W'(bypShift));
    assign wrAddr[i] = tail + FQ_PTR_W'(laneOff[i]) - FQ_PTR_W'(bypShift);
    assign wrData[i] = laneEntry[i];
  end

  for (genvar k = 0; k < DEQ_WIDTH; k++) begin : gSlot
    assign rdAddr[k] = head + FQ_PTR_W'(k);
    assign deqInst_o[k*INST_W +: INST_W] = slotEntry[k].inst;
    assign deqPC_o[k*PC_W +: PC_W]       = slotEntry[k].pc;
    assign deqExc_o[k]                   = slotEntry[k].exc;
  end

  fetch_queue_ram #(
    .DEPTH(DEPTH), .WR_PORTS(FETCH_WIDTH), .RD_PORTS(DEQ_WIDTH), .AW(FQ_PTR_W)
  ) uRam (
    .clk(clk), .we(wrEn), .waddr(wrAddr), .wdata(wrData), .raddr(rdAddr), .rdata(rdData)
  );

  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      slotEntry[k]  = fqEntry_t'(rdData[k]);
      deqValid_o[k] = CNT_W'(unsigned'(k)) < count;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      for (int k = 0; k < DEQ_WIDTH; k++) begin
        slotEntry[k]  = '0;
        deqValid_o[k] = FQ_LANE_W'(unsigned'(k)) < enqTotal;
        for (int i = 0; i < FETCH_WIDTH; i++)
          if (effValid[i] && laneOff[i] == FQ_LANE_W'(unsigned'(k))) slotEntry[k] = laneEntry[i];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + FQ_PTR_W'(deqCnt_i) - FQ_PTR_W'(bypShift);
      tail  <= tail + FQ_PTR_W'(enqCnt) - FQ_PTR_W'(bypShift);
      count <= count + CNT_W'(enqCnt) - CNT_W'(deqCnt_i);
    end
  end

  assign count_o = count;

  aDeqLegal: assert property (@(posedge clk) disable iff (reset)
    deqCnt_i <= DC_W'($countones(deqValid_o)))
    else $error("deqCnt_i exceeds valid dequeue slots");
endmodule

// File: tb/tb_fetch_inst_queue.sv
module tb_fetch_inst_queue;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        exc;
  } expEntry_t;

  logic         clk = 0;
  logic         reset = 1;
  logic         flush = 0;
  logic [63:0]  fetchPC = '0;
  logic [127:0] inst = '0;
  logic [3:0]   instValid = '0;
  logic         instExc = 0;
  logic         fqReady;
  logic [127:0] deqInst;
  logic [255:0] deqPC;
  logic [3:0]   deqExc, deqValid;
  logic [2:0]   deqCnt = '0;
  logic [4:0]   count;

  expEntry_t sb[$];
  int nPass = 0, nChecks = 0;
  int mCount = 0;

  fetch_inst_queue dut (
    .clk(clk), .reset(reset), .flush_i(flush), .fetchPC_i(fetchPC), .inst_i(inst),
    .instValid_i(instValid), .instExc_i(instExc), .fqReady_o(fqReady),
    .deqInst_o(deqInst), .deqPC_o(deqPC), .deqExc_o(deqExc), .deqValid_o(deqValid),
    .deqCnt_i(deqCnt), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] instOf(input logic [63:0] pc);
    return ~pc[31:0];
  endfunction

  // Monitor: every slot decode consumes is popped off the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(deqCnt); k++) begin
        expEntry_t e;
        if (sb.size() == 0) begin
          nChecks++;
          $display("FAIL sb_underflow: got slot %0d consumed expected no entry", k);
        end else begin
          e = sb.pop_front();
          chk("mon_valid", 64'(deqValid[k]), 64'd1);
          chk("mon_pc",    deqPC[k*64 +: 64], e.pc);
          chk("mon_inst",  64'(deqInst[k*32 +: 32]), 64'(e.inst));
          chk("mon_exc",   64'(deqExc[k]), 64'(e.exc));
        end
      end
    end
  end

  int pendN;
  logic pendFlush;

  task automatic drive(input logic [63:0] pc, input logic [3:0] v, input logic exc,
                       input int dq, input logic fl);
    logic [3:0] eff;
    expEntry_t e;
    fetchPC = pc; instValid = v; instExc = exc; deqCnt = 3'(dq); flush = fl;
    for (int i = 0; i < 4; i++) inst[i*32 +: 32] = instOf(pc + 64'(4*i));
    eff = v;
    if (exc) begin
      eff = 4'b0001;
      for (int i = 3; i >= 0; i--) if (v[i]) eff = 4'b0001 << i;
    end
    pendN = 0;
    pendFlush = fl;
    if ((16 - mCount) >= 4 && !fl) begin
      for (int i = 0; i < 4; i++) if (eff[i]) begin
        e.pc = pc + 64'(4*i); e.inst = instOf(e.pc); e.exc = exc;
        sb.push_back(e);
        pendN++;
      end
    end
    mCount = pendFlush ? 0 : mCount + pendN - dq;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (pendFlush) sb.delete();
    flush = 0; instValid = '0; instExc = 0; deqCnt = '0;
  endtask

  task automatic cyc(input logic [63:0] pc, input logic [3:0] v, input logic exc,
                     input int dq, input logic fl);
    drive(pc, v, exc, dq, fl);
    tick();
  endtask

  task automatic doReset();
    reset = 1; instValid = '0; deqCnt = '0; flush = 0;
    @(posedge clk); #1;
    reset = 0; sb.delete(); mCount = 0;
  endtask

  initial begin
    doReset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fqReady), 64'd1);
    chk("rst_valid", 64'(deqValid), 64'd0);

    // Full group
    cyc(64'h1000, 4'b1111, 0, 0, 0);
    chk("t1_valid", 64'(deqValid), 64'hF);
    chk("t1_count", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) chk("t1_pc", deqPC[k*64 +: 64], 64'h1000 + 64'(4*k));
    cyc(0, 4'b0000, 0, 4, 0);
    chk("t1_drain", 64'(count), 64'd0);

    // Sparse group compaction
    cyc(64'h2000, 4'b1010, 0, 0, 0);
    chk("t2_valid", 64'(deqValid), 64'h3);
    chk("t2_pc0", deqPC[63:0], 64'h2004);
    chk("t2_pc1", deqPC[127:64], 64'h200C);
    cyc(0, 4'b0000, 0, 2, 0);

    // Fill to full, backpressure, release
    cyc(64'h4000, 4'b1111, 0, 0, 0); chk("t3_c4", 64'(count), 64'd4);
    cyc(64'h4010, 4'b1111, 0, 0, 0); chk("t3_c8", 64'(count), 64'd8);
    cyc(64'h4020, 4'b1111, 0, 0, 0); chk("t3_c12", 64'(count), 64'd12);
    chk("t3_ready12", 64'(fqReady), 64'd1);
    cyc(64'h4030, 4'b1111, 0, 0, 0); chk("t3_c16", 64'(count), 64'd16);
    chk("t3_ready16", 64'(fqReady), 64'd0);
    cyc(64'h4040, 4'b1111, 0, 0, 0); chk("t3_ignored", 64'(count), 64'd16);
    cyc(64'h4050, 4'b1111, 0, 4, 0); chk("t3_deq", 64'(count), 64'd12);
    chk("t3_ready_back", 64'(fqReady), 64'd1);
    cyc(0, 4'b0000, 0, 4, 0);
    cyc(0, 4'b0000, 0, 4, 0);
    cyc(0, 4'b0000, 0, 4, 0);
    chk("t3_empty", 64'(count), 64'd0);

    // Reset mid-operation
    cyc(64'h4100, 4'b1111, 0, 0, 0);
    doReset();
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_valid", 64'(deqValid), 64'd0);

    // Wrap with overlapped enqueue/dequeue
    cyc(64'h5000, 4'b1111, 0, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      cyc(64'h5000 + 64'(16*j), 4'b1111, 0, 4, 0);
      chk("t4_count", 64'(count), 64'd4);
    end
    cyc(64'h5060, 4'b1111, 0, 0, 0);
    cyc(64'h5070, 4'b1111, 0, 0, 0);
    cyc(64'h5080, 4'b1111, 0, 4, 0);
    chk("t4_c12_enqdeq", 64'(count), 64'd12);

    // Flush wins over enqueue and dequeue
    cyc(64'h6000, 4'b1111, 0, 2, 1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(deqValid), 64'd0);
    chk("t5_ready", 64'(fqReady), 64'd1);
    cyc(64'h6100, 4'b1111, 0, 0, 0);
    chk("t5_pc0", deqPC[63:0], 64'h6100);
    chk("t5_pc3", deqPC[255:192], 64'h610C);
    cyc(0, 4'b0000, 0, 4, 0);

    // Exception groups
    drive(64'h3000, 4'b0110, 1, 0, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    #1;
    chk("t6_byp_valid", 64'(deqValid[0]), 64'd1);
    chk("t6_byp_pc", deqPC[63:0], 64'h3004);
`endif
    tick();
    chk("t6_count", 64'(count), 64'd1);
    chk("t6_valid", 64'(deqValid), 64'h1);
    chk("t6_pc", deqPC[63:0], 64'h3004);
    chk("t6_exc", 64'(deqExc[0]), 64'd1);
    cyc(64'h3100, 4'b0000, 1, 0, 0);
    chk("t6_none_valid", 64'(deqValid), 64'h3);
    chk("t6_none_pc", deqPC[127:64], 64'h3100);
    cyc(64'h3200, 4'b1111, 0, 2, 0);
    chk("t6_mix_count", 64'(count), 64'd4);
    cyc(0, 4'b0000, 0, 4, 0);
    chk("end_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    cyc(0, 4'b0000, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
